// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_NINE    = 4'd9;

    // Largest value representable with the given number of decimal digits.
    function automatic logic [31:0] bcd_limit(input int digits);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 32'd10;
        end
        return v - 32'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One BCD digit correction cell: add 3 when the digit is 5 or more.
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= ADD3_THRESH) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter with start/busy/done handshake and held outputs.
// Leading-zero blanking is built only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      ovf,
    output logic [DIGITS-1:0]         blank
);

    localparam int          SW    = DIGIT_W * DIGITS;
    localparam int          CW    = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT = bcd_limit(DIGITS);

    state_e           state_q;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [SW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_pend_q;
    logic             busy_q, done_q, ovf_q;
    logic [SW-1:0]    bcd_q;
    logic [SW-1:0]    adj;
    logic [SW+BIN_W-1:0] cat_d;
    logic             accept;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dd
        dabble_digit u_dd (
            .d_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .d_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Digits beyond the top one fall off here; ovf saturation covers that case.
    assign cat_d     = {adj, shift_q} << 1;
    assign scratch_d = cat_d[SW+BIN_W-1:BIN_W];
    assign shift_d   = cat_d[BIN_W-1:0];
    assign cnt_d     = cnt_q - CW'(1);
    assign accept    = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q == SHIFT);
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_d;
                    if (cnt_q == CW'(1)) state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    bcd_q   <= ovf_pend_q ? {DIGITS{BCD_NINE}} : scratch_q;
                    ovf_q   <= ovf_pend_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Acceptance overrides the DONE->IDLE move, giving back-to-back conversions.
            if (accept) begin
                shift_q    <= bin;
                scratch_q  <= '0;
                cnt_q      <= CW'(BIN_W);
                ovf_pend_q <= (32'(bin) > LIMIT);
                state_q    <= SHIFT;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              hi_zero;

    always_comb begin
        blank_d = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero && (scratch_q[i*DIGIT_W +: DIGIT_W] == 4'd0);
            blank_d[i] = hi_zero && !ovf_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blank_q <= '0;
        end else if (state_q == DONE) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a cycle-level behavioural model.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [BIN_W-1:0]  bin = '0;
    logic              busy, done, ovf;
    logic [15:0]       bcd;
    logic [3:0]        blank;

    int vectors = 0;
    int miscompares = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: decimal digits by repeated division.
    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] blank_of(input int unsigned v);
        logic [3:0] b;
        int unsigned p;
        b = '0;
        p = 1;
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            b[i] = BLANK_ON && (v < p);
        end
        return b;
    endfunction

    // Timing model: accept at edge k, busy after k+1..k+BIN_W, done after k+BIN_W+1.
    int          edge_n = 0;
    bit          active = 0;
    int          acc_edge = 0;
    int unsigned cap_bin = 0;
    logic        exp_busy = 0, exp_done = 0, exp_ovf = 0;
    logic [15:0] exp_bcd = '0;
    logic [3:0]  exp_blank = '0;

    always @(posedge clk) begin
        edge_n++;
        if (!rst) begin
            active = 0; exp_busy = 0; exp_done = 0;
            exp_bcd = '0; exp_ovf = 0; exp_blank = '0;
        end else begin
            exp_done = 0;
            if (active && edge_n == acc_edge + BIN_W + 1) begin
                active   = 0;
                exp_done = 1;
                exp_ovf  = (cap_bin > 9999);
                exp_bcd  = exp_ovf ? 16'h9999 : to_bcd(cap_bin);
                exp_blank = exp_ovf ? 4'b0 : blank_of(cap_bin);
            end
            if (start && !active) begin
                active   = 1;
                acc_edge = edge_n;
                cap_bin  = int'(bin);
            end
            exp_busy = active && edge_n > acc_edge && edge_n <= acc_edge + BIN_W;
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            vectors++;
            if ({busy, done, bcd, ovf, blank} !== {exp_busy, exp_done, exp_bcd, exp_ovf, exp_blank}) begin
                miscompares++;
                if (miscompares < 30)
                    $display("FAIL cyc%0d: busy/done/bcd/ovf/blank got %b/%b/%h/%b/%b expected %b/%b/%h/%b/%b",
                             edge_n, busy, done, bcd, ovf, blank,
                             exp_busy, exp_done, exp_bcd, exp_ovf, exp_blank);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns edges from acceptance to the done pulse, and busy cycles seen meanwhile.
    task automatic wait_done(output int lat, output int nbusy);
        lat = -1;
        nbusy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic convert(input int unsigned v, output int lat, output int nbusy);
        bin = BIN_W'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, nbusy);
    endtask

    initial begin
        int lat, nb;
        repeat (3) tick();
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();

        convert(0, lat, nb);
        chk("lat0", lat, 15);
        chk("bcd0", 32'(bcd), 32'h0000);
        chk("blank0", 32'(blank), BLANK_ON ? 32'he : 32'h0);

        convert(1234, lat, nb);
        chk("busy1234", nb, 14);
        chk("bcd1234", 32'(bcd), 32'h1234);
        chk("ovf1234", 32'(ovf), 32'h0);

        convert(9999, lat, nb);
        chk("bcd9999", 32'(bcd), 32'h9999);
        chk("ovf9999", 32'(ovf), 32'h0);
        convert(12000, lat, nb);
        chk("bcd12000", 32'(bcd), 32'h9999);
        chk("ovf12000", 32'(ovf), 32'h1);
        chk("blank12000", 32'(blank), 32'h0);

        // start held: 7 then 42 back-to-back
        bin = 14'd7;
        start = 1'b1;
        tick();
        bin = 14'd42;
        wait_done(lat, nb);
        chk("bcd7", 32'(bcd), 32'h0007);
        start = 1'b0;
        wait_done(lat, nb);
        chk("lat42", lat, 14);
        chk("bcd42", 32'(bcd), 32'h0042);
        chk("blank42", 32'(blank), BLANK_ON ? 32'hc : 32'h0);

        // start pulsed mid-conversion is ignored
        bin = 14'd300;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin = 14'd555;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, nb);
        chk("bcd300", 32'(bcd), 32'h0300);

        // reset mid-conversion aborts
        bin = 14'd8765;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        repeat (20) tick();
        convert(4321, lat, nb);
        chk("bcd4321", 32'(bcd), 32'h4321);

        // random phase, model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0: bin = BIN_W'($urandom_range(0, 99));
                1: bin = BIN_W'($urandom_range(0, 9999));
                2: bin = BIN_W'($urandom_range(9990, 10010));
                default: bin = BIN_W'($urandom_range(0, 16383));
            endcase
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end
        start = 1'b0;
        rst = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
